// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN post-processing stages.
//   DATA_W  : convolution result width (two's complement)
//   POOL_W  : post-ReLU / pooled value width (unsigned)
//   MAX_W   : largest supported feature-map width
//   LB_*    : pooling line-buffer geometry (one entry per column pair)
//   state_t : pooling-stage FSM encoding
package cnn_pkg;

    localparam int DATA_W   = 21;
    localparam int POOL_W   = DATA_W - 1;
    localparam int MAX_W    = 256;
    localparam int DIM_W    = 9;
    localparam int LB_DEPTH = MAX_W / 2;
    localparam int LB_AW    = $clog2(LB_DEPTH);

    localparam logic [DIM_W-1:0] MAX_W_DIM = DIM_W'(MAX_W);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Negative results clamp to zero; the producer saturates, so the
    // remaining magnitude always fits POOL_W bits.
    function automatic logic [POOL_W-1:0] relu(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? '0 : x[DATA_W-2:0];
    endfunction

    function automatic logic [POOL_W-1:0] umax(input logic [POOL_W-1:0] a,
                                               input logic [POOL_W-1:0] b);
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/relu_maxpool_if.sv
// Stream/control bundle between the convolution MAC side and relu_maxpool.
//   master : frame control + convolution results in, pooled results out
//   slave  : the pooling stage itself
interface relu_maxpool_if;
    import cnn_pkg::*;

    logic                clear;
    logic                start;
    logic [DIM_W-1:0]    map_width;
    logic [DIM_W-1:0]    map_height;
    logic [DATA_W-1:0]   in_data;
    logic                in_valid;
    logic [POOL_W-1:0]   out;
    logic                done;
    logic                frame_done;
    logic                busy;
    logic                cfg_err;

    modport master (
        output clear, start, map_width, map_height, in_data, in_valid,
        input  out, done, frame_done, busy, cfg_err
    );

    modport slave (
        input  clear, start, map_width, map_height, in_data, in_valid,
        output out, done, frame_done, busy, cfg_err
    );

endinterface

// File: rtl/pool_line_buffer.sv
// Simple dual-port line buffer holding the pair-max of each column pair of
// the previous (even) row.
//   clk          : clock
//   we/waddr/wdata : synchronous write port
//   re/raddr     : read request; rdata is registered and holds until the
//                  next read
module pool_line_buffer
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [LB_AW-1:0]  waddr,
    input  logic [POOL_W-1:0] wdata,
    input  logic              re,
    input  logic [LB_AW-1:0]  raddr,
    output logic [POOL_W-1:0] rdata
);

    logic [POOL_W-1:0] mem [LB_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/relu_maxpool.sv
// ReLU followed by 2x2 stride-2 max pooling over a raster-ordered map.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of relu_maxpool_if
//              (clear/start/map_width/map_height/in_data/in_valid in,
//               out/done/frame_done/busy/cfg_err out)
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | waiting for a start with legal dimensions
// RUN   | consuming H*W results of the current frame
module relu_maxpool
    import cnn_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    relu_maxpool_if.slave  bus
);

    state_t             state_q, state_d;
    logic [DIM_W-1:0]   w_q, h_q, col_q, row_q;
    logic [POOL_W-1:0]  hold_q, out_q;
    logic               done_q, frame_done_q, busy_q, cfg_err_q;

    logic               accept, last_col, last_row, frame_end, dims_ok;
    logic [POOL_W-1:0]  v, pm, win;
    logic               lb_we, lb_re;
    logic [LB_AW-1:0]   lb_addr;
    logic [POOL_W-1:0]  lb_rdata;

    always_comb begin
        v         = relu(bus.in_data);
        pm        = umax(hold_q, v);
        win       = umax(pm, lb_rdata);
        accept    = (state_q == RUN) && bus.in_valid;
        last_col  = (col_q == w_q - DIM_W'(1));
        last_row  = (row_q == h_q - DIM_W'(1));
        frame_end = accept && last_col && last_row;
        dims_ok   = (bus.map_width >= DIM_W'(2)) && (bus.map_width <= MAX_W_DIM) &&
                    (bus.map_height >= DIM_W'(2));
        lb_addr   = col_q[LB_AW:1];
        // The trailing row of an odd-height map never forms a window, so
        // it must not disturb the buffer.
        lb_we     = accept && col_q[0] && !row_q[0] && !last_row;
        // Read is issued on the even column so registered data is ready
        // for a back-to-back odd column.
        lb_re     = accept && !col_q[0] && row_q[0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start && dims_ok) state_d = RUN;
            RUN:  if (frame_end)            state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            state_q      <= IDLE;
            w_q          <= '0;
            h_q          <= '0;
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            out_q        <= '0;
            done_q       <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            if (rst) begin
                cfg_err_q <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            done_q       <= 1'b0;
            frame_done_q <= 1'b0;

            if (state_q == IDLE && bus.start) begin
                if (dims_ok) begin
                    w_q       <= bus.map_width;
                    h_q       <= bus.map_height;
                    col_q     <= '0;
                    row_q     <= '0;
                    busy_q    <= 1'b1;
                    cfg_err_q <= 1'b0;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end

            if (accept) begin
                if (last_col) begin
                    col_q <= '0;
                    row_q <= last_row ? '0 : row_q + DIM_W'(1);
                end else begin
                    col_q <= col_q + DIM_W'(1);
                end

                // On odd widths the last column lands here as an even
                // column and is simply overwritten by the next row.
                if (!col_q[0]) begin
                    hold_q <= v;
                end else if (row_q[0]) begin
                    out_q  <= win;
                    done_q <= 1'b1;
                end

                if (frame_end) begin
                    frame_done_q <= 1'b1;
                    busy_q       <= 1'b0;
                end
            end
        end
    end

    pool_line_buffer u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (pm),
        .re    (lb_re),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    assign bus.out        = out_q;
    assign bus.done       = done_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
    assign bus.cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_relu_maxpool.sv
module tb_relu_maxpool;
    import cnn_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    relu_maxpool_if bus();

    relu_maxpool dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   obs[$];
    int   pix[$];
    int   exp_q[$];
    int   fd_n = 0;
    int   fd_cyc = 0;
    logic fd_coinc = 1'b0;
    int   done_n = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.done) begin
            obs.push_back(int'(bus.out));
            done_n++;
        end
        if (bus.frame_done) begin
            fd_n++;
            fd_cyc   = cyc;
            fd_coinc = bus.done;
        end
    end

    // Reference: every complete 2x2 window in raster order, max of ReLU.
    function automatic void model(input int w, input int h);
        exp_q.delete();
        for (int wy = 0; wy < h / 2; wy++) begin
            for (int wx = 0; wx < w / 2; wx++) begin
                int m = 0;
                for (int dy = 0; dy < 2; dy++) begin
                    for (int dx = 0; dx < 2; dx++) begin
                        int p = pix[(2 * wy + dy) * w + 2 * wx + dx];
                        if (p < 0) p = 0;
                        if (p > m) m = p;
                    end
                end
                exp_q.push_back(m);
            end
        end
    endfunction

    function automatic int rand_data();
        return int'($urandom_range(0, 2097151)) - 1048576;
    endfunction

    task automatic do_start(input int w, input int h);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.map_width  = 9'(w);
        bus.map_height = 9'(h);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
    endtask

    task automatic drive_pix(input int val, input int gap);
        bus.in_data  = 21'(val);
        bus.in_valid = 1'b1;
        last_cyc     = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Runs one frame from pix[]; gap < 0 means random gaps 0..2.
    task automatic run_frame(input string name, input int w, input int h,
                             input int gap, input bit poke_start);
        obs.delete();
        fd_n = 0;
        model(w, h);
        do_start(w, h);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s busy_after_start: got %0b expected 1", name, bus.busy);
        end
        for (int i = 0; i < w * h; i++) begin
            int g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            if (poke_start && i == 2) begin
                bus.start      = 1'b1;
                bus.map_width  = 9'd3;
                bus.map_height = 9'd3;
            end
            drive_pix(pix[i], g);
        end
        repeat (4) @(negedge clk);
        #1;
        n_cmp++;
        if (fd_n !== 1) begin
            n_bad++;
            $display("FAIL %s frame_done_count: got %0d expected 1", name, fd_n);
        end
        n_cmp++;
        if (fd_cyc !== last_cyc + 1) begin
            n_bad++;
            $display("FAIL %s frame_done_cycle: got %0d expected %0d", name, fd_cyc, last_cyc + 1);
        end
        n_cmp++;
        if (fd_coinc !== ((w % 2 == 0) && (h % 2 == 0))) begin
            n_bad++;
            $display("FAIL %s frame_done_with_done: got %0b expected %0b", name, fd_coinc,
                     (w % 2 == 0) && (h % 2 == 0));
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy_after_frame: got %0b expected 0", name, bus.busy);
        end
        n_cmp++;
        if (obs.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL %s output_count: got %0d expected %0d", name, obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL %s out[%0d]: got %0d expected %0d", name, i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        n_cmp++;
        if ({bus.out, bus.done, bus.frame_done, bus.busy, bus.cfg_err} !== '0) begin
            n_bad++;
            $display("FAIL %s outputs_zero: got out=%0d done=%0b fd=%0b busy=%0b err=%0b expected all 0",
                     name, bus.out, bus.done, bus.frame_done, bus.busy, bus.cfg_err);
        end
    endtask

    task automatic fill_seq(input int n);
        pix.delete();
        for (int i = 1; i <= n; i++) pix.push_back(i);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("reset");
    endtask

    task automatic test_seq_4x4();
        fill_seq(16);
        run_frame("seq4x4", 4, 4, 0, 1'b0);
        n_cmp++;
        if (obs.size() == 4 && (obs[0] !== 6 || obs[1] !== 8 || obs[2] !== 14 || obs[3] !== 16)) begin
            n_bad++;
            $display("FAIL seq4x4 literal: got %0d %0d %0d %0d expected 6 8 14 16",
                     obs[0], obs[1], obs[2], obs[3]);
        end
    endtask

    task automatic test_negative_2x2();
        pix = '{-5, -1, -1048576, -7};
        run_frame("neg2x2", 2, 2, 0, 1'b0);
    endtask

    task automatic test_odd_5x3();
        fill_seq(15);
        run_frame("odd5x3", 5, 3, 3, 1'b0);
    endtask

    task automatic test_clear_abort();
        fill_seq(16);
        fd_n = 0;
        do_start(4, 4);
        for (int i = 0; i < 6; i++) drive_pix(pix[i], 0);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (fd_n !== 0) begin
            n_bad++;
            $display("FAIL clear frame_done_on_abort: got %0d expected 0", fd_n);
        end
        check_all_zero("clear");
        run_frame("after_clear", 4, 4, 0, 1'b0);
    endtask

    task automatic test_cfg_err();
        int d0;
        do_start(1, 4);
        n_cmp++;
        if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL cfg_w1: got err=%0b busy=%0b expected err=1 busy=0", bus.cfg_err, bus.busy);
        end
        d0 = done_n;
        fd_n = 0;
        for (int i = 0; i < 4; i++) drive_pix(i + 50, 0);
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (done_n !== d0 || fd_n !== 0) begin
            n_bad++;
            $display("FAIL cfg_ignored_inputs: got done=%0d fd=%0d expected done=%0d fd=0",
                     done_n - d0, fd_n, 0);
        end
        do_start(257, 2);
        n_cmp++;
        if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL cfg_w257: got err=%0b busy=%0b expected err=1 busy=0", bus.cfg_err, bus.busy);
        end
        do_start(4, 1);
        n_cmp++;
        if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL cfg_h1: got err=%0b busy=%0b expected err=1 busy=0", bus.cfg_err, bus.busy);
        end
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        #1;
        n_cmp++;
        if (bus.cfg_err !== 1'b1) begin
            n_bad++;
            $display("FAIL cfg_kept_by_clear: got %0b expected 1", bus.cfg_err);
        end
        pix = '{3, 9, 4, 2};
        run_frame("cfg_recover", 2, 2, 0, 1'b0);
        n_cmp++;
        if (bus.cfg_err !== 1'b0) begin
            n_bad++;
            $display("FAIL cfg_cleared: got %0b expected 0", bus.cfg_err);
        end
    endtask

    task automatic test_rst_midframe();
        int d0;
        fill_seq(16);
        do_start(4, 4);
        for (int i = 0; i < 7; i++) drive_pix(pix[i], 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        d0 = done_n;
        fd_n = 0;
        for (int i = 0; i < 8; i++) drive_pix(rand_data(), 0);
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (done_n !== d0 || fd_n !== 0) begin
            n_bad++;
            $display("FAIL idle_inputs: got done=%0d fd=%0d expected 0 0", done_n - d0, fd_n);
        end
        check_all_zero("idle_inputs");
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            int w = int'($urandom_range(2, 12));
            int h = int'($urandom_range(2, 9));
            pix.delete();
            for (int i = 0; i < w * h; i++) pix.push_back(rand_data());
            run_frame($sformatf("rand%0d_%0dx%0d", k, w, h), w, h, -1, k == 1);
        end
    endtask

    task automatic test_back_to_back();
        pix.delete();
        for (int i = 0; i < 256 * 2; i++) pix.push_back(rand_data());
        run_frame("maxw256x2", 256, 2, 0, 1'b0);
        pix.delete();
        for (int i = 0; i < 2 * 3; i++) pix.push_back(rand_data());
        run_frame("min2x3", 2, 3, 0, 1'b0);
    endtask

    initial begin
        bus.clear      = 1'b0;
        bus.start      = 1'b0;
        bus.map_width  = '0;
        bus.map_height = '0;
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        test_reset();
        test_seq_4x4();
        test_negative_2x2();
        test_odd_5x3();
        test_clear_abort();
        test_cfg_err();
        test_rst_midframe();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
